dec5_to_32: RTL and testbench

DEC5_TO_32 -- requirements
Module: dec5_to_32

---
 rtl/dec5_to_32.sv | 65 ++++++
 tb/tb_dec5_to_32.sv | 129 ++++++++++++
 2 files changed

// File: rtl/dec5_to_32.sv
// dec5_to_32 -- 5-to-32 one-hot address decoder with a registered copy.
//
// Ports:
//   Clk   in   1  : clock; all state updates on its rising edge
//   Rst   in   1  : synchronous active-high reset (clears OutQ and Valid)
//   Adr   in   5  : address to decode
//   En    in   1  : capture enable for the registered decode
//   Out   out 32  : combinational one-hot decode of Adr (independent of Clk/Rst/En)
//   OutQ  out 32  : decode of Adr captured on the last enabled edge
//   Valid out  1  : high once OutQ holds a captured decode
//
// Out is built one bit per address with a plain equality compare, so it is
// purely combinational and always exactly one-hot. The registered path
// captures that same decode, so OutQ is either all-zero (after reset) or
// one-hot (after any capture), and the two paths cannot disagree.
module dec5_to_32 (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  Adr,
  input  logic        En,
  output logic [31:0] Out,
  output logic [31:0] OutQ,
  output logic        Valid
);

  logic [31:0] dec_d;
  logic [31:0] outq_q;
  logic        valid_q;
  logic [31:0] outq_d;
  logic        valid_d;

  // One comparator per output bit; every 5-bit address hits exactly one bit.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_dec
      assign dec_d[gi] = (Adr == 5'(gi));
    end
  endgenerate

  assign Out = dec_d;

  // Next-state: load the decode when enabled, otherwise hold.
  always_comb begin
    outq_d  = outq_q;
    valid_d = valid_q;
    if (En) begin
      outq_d  = dec_d;
      valid_d = 1'b1;
    end
  end

  // Reset takes priority over the enable.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      outq_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      outq_q  <= outq_d;
      valid_q <= valid_d;
    end
  end

  assign OutQ  = outq_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_dec5_to_32.sv
// tb_dec5_to_32 -- directed-vector bench for dec5_to_32.
// Inputs change on the falling edge; registered outputs are sampled 1 ns
// after the rising edge. Expected values are hand-derived constants or
// 1 << address computed here.
module tb_dec5_to_32;

  logic        Clk;
  logic        Rst;
  logic [4:0]  Adr;
  logic        En;
  logic [31:0] Out;
  logic [31:0] OutQ;
  logic        Valid;

  int n_tests;
  int n_fail;

  dec5_to_32 dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Adr   (Adr),
    .En    (En),
    .Out   (Out),
    .OutQ  (OutQ),
    .Valid (Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] one;
    logic [31:0] exp;
    one     = 32'h1;
    n_tests = 0;
    n_fail  = 0;
    Rst     = 1'b1;
    En      = 1'b0;
    Adr     = 5'd0;

    // Combinational sweep, one address every 5 ns, clock irrelevant.
    for (int a = 0; a < 32; a++) begin
      Adr = 5'(a);
      #5;
      exp = one << a;
      check($sformatf("sweep_out[%0d]", a), Out, exp);
      check($sformatf("sweep_pop[%0d]", a), 32'($countones(Out)), 32'd1);
    end

    // Reset held two cycles with En=1, Adr=7.
    @(negedge Clk);
    Rst = 1'b1; En = 1'b1; Adr = 5'd7;
    for (int c = 0; c < 2; c++) begin
      @(posedge Clk); #1;
      check($sformatf("rst_outq[%0d]", c), OutQ, 32'h0000_0000);
      check($sformatf("rst_valid[%0d]", c), {31'b0, Valid}, 32'd0);
      check($sformatf("rst_out[%0d]", c), Out, 32'h0000_0080);
    end

    // Release reset, capture Adr=5.
    @(negedge Clk);
    Rst = 1'b0; En = 1'b1; Adr = 5'd5;
    @(posedge Clk); #1;
    check("cap5_outq", OutQ, 32'h0000_0020);
    check("cap5_valid", {31'b0, Valid}, 32'd1);

    // Hold with En=0 while Adr moves to 20.
    @(negedge Clk);
    En = 1'b0; Adr = 5'd20;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      check($sformatf("hold_outq[%0d]", c), OutQ, 32'h0000_0020);
      check($sformatf("hold_valid[%0d]", c), {31'b0, Valid}, 32'd1);
      check($sformatf("hold_out[%0d]", c), Out, 32'h0010_0000);
    end

    // Reset and enable on the same edge: reset wins.
    @(negedge Clk);
    Rst = 1'b1; En = 1'b1; Adr = 5'd31;
    @(posedge Clk); #1;
    check("rst_en_outq", OutQ, 32'h0000_0000);
    check("rst_en_valid", {31'b0, Valid}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk); #1;
    check("resume_outq", OutQ, 32'h8000_0000);
    check("resume_valid", {31'b0, Valid}, 32'd1);

    // Only the address present at the edge is captured.
    @(negedge Clk);
    Adr = 5'd3;
    #4;
    Adr = 5'd9;
    @(posedge Clk); #1;
    Adr = 5'd12;
    check("mid_change_outq", OutQ, 32'h0000_0200);

    // Capture every address on consecutive edges.
    for (int a = 0; a < 32; a++) begin
      @(negedge Clk);
      En = 1'b1; Adr = 5'(a);
      @(posedge Clk); #1;
      exp = one << a;
      check($sformatf("pipe_outq[%0d]", a), OutQ, exp);
      check($sformatf("pipe_pop[%0d]", a), 32'($countones(OutQ)), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
